// File: rtl/tlb_miss_walker.sv
// tlb_miss_walker
//
// Two-level hardware page-table walker that services TLB misses for one core.
// A miss is accepted in IDLE only. The walker reads the page-directory entry,
// then the leaf page-table entry, over a single-outstanding memory read port.
// It then issues one TLB update command, or reports a fault. A flush
// (abort_en) abandons the walk. Any request already accepted by memory still
// has its response absorbed before the walker returns to IDLE.
//
// PTE format: [ADDR_WIDTH-1:PAGE_BITS] physical page, bit0 present,
//             bit1 exe/writable, bit2 supervisor, bit3 global.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   miss_valid/miss_ready      miss handshake (ready only in IDLE)
//   miss_vpage_idx, miss_asid  missing virtual page index and address space
//   page_dir_base              page-directory physical base, sampled on accept
//   abort_en                   flush: abandon the walk, no TLB update
//   mem_req_valid/ready/addr   PTE read request (word-aligned address)
//   mem_resp_valid/data        PTE read response, one per accepted request
//   update_en + update_*       one-cycle TLB update command and its fields
//   walk_done, walk_fault      one-cycle completion pulse, fault qualifier

module tlb_miss_walker #(
  parameter int ADDR_WIDTH     = 32,
  parameter int PAGE_BITS      = 12,
  parameter int DIR_INDEX_BITS = 10,
  parameter int ASID_WIDTH     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            miss_valid,
  output logic                            miss_ready,
  input  logic [ADDR_WIDTH-PAGE_BITS-1:0] miss_vpage_idx,
  input  logic [ASID_WIDTH-1:0]           miss_asid,
  input  logic [ADDR_WIDTH-1:0]           page_dir_base,
  input  logic                            abort_en,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  input  logic                            mem_resp_valid,
  input  logic [ADDR_WIDTH-1:0]           mem_resp_data,
  output logic                            update_en,
  output logic [ADDR_WIDTH-PAGE_BITS-1:0] update_vpage_idx,
  output logic [ASID_WIDTH-1:0]           update_asid,
  output logic [ADDR_WIDTH-PAGE_BITS-1:0] update_ppage_idx,
  output logic                            update_present,
  output logic                            update_exe_writable,
  output logic                            update_supervisor,
  output logic                            update_global,
  output logic                            walk_done,
  output logic                            walk_fault
);

  localparam int VPN_W    = ADDR_WIDTH - PAGE_BITS;
  localparam int TBL_BITS = VPN_W - DIR_INDEX_BITS;

  typedef enum logic [2:0] {
    IDLE, DIR_REQ, DIR_WAIT, TBL_REQ, TBL_WAIT, UPDATE, FAULT, DRAIN
  } state_t;

  state_t state;

  // Control registers (reset)
  logic req_valid_q;
  logic upd_q;
  logic done_q;
  logic fault_q;

  // Walk context and PTE data (not reset; only observed through gated outputs)
  logic [VPN_W-1:0]      vpage_q;
  logic [ASID_WIDTH-1:0] asid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [VPN_W-1:0]      ppage_q;
  logic [3:0]            flags_q;

  logic [ADDR_WIDTH-1:0] dir_off;
  logic [ADDR_WIDTH-1:0] tbl_addr;
  logic                  unused_pte_bits;

  // Directory entry offset: upper page-index bits scaled to a word address.
  // The base add wraps modulo 2^ADDR_WIDTH.
  assign dir_off  = ADDR_WIDTH'({miss_vpage_idx[VPN_W-1 -: DIR_INDEX_BITS], 2'b00});
  assign tbl_addr = {mem_resp_data[ADDR_WIDTH-1:PAGE_BITS], vpage_q[TBL_BITS-1:0], 2'b00};
  assign unused_pte_bits = ^mem_resp_data[PAGE_BITS-1:4];

  // Walk sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_valid_q <= 1'b0;
      upd_q       <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_valid) begin
            vpage_q     <= miss_vpage_idx;
            asid_q      <= miss_asid;
            addr_q      <= page_dir_base + dir_off;
            req_valid_q <= 1'b1;
            state       <= DIR_REQ;
          end
        end
        DIR_REQ, TBL_REQ: begin
          if (abort_en) begin
            req_valid_q <= 1'b0;
            // A request that handshakes in the abort cycle still owes a response.
            if (mem_req_ready) begin
              state <= DRAIN;
            end else begin
              done_q <= 1'b1;
              state  <= FAULT;
            end
          end else if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= (state == DIR_REQ) ? DIR_WAIT : TBL_WAIT;
          end
        end
        DIR_WAIT: begin
          if (abort_en) begin
            if (mem_resp_valid) begin
              done_q <= 1'b1;
              state  <= FAULT;
            end else begin
              state <= DRAIN;
            end
          end else if (mem_resp_valid) begin
            if (!mem_resp_data[0]) begin
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              addr_q      <= tbl_addr;
              req_valid_q <= 1'b1;
              state       <= TBL_REQ;
            end
          end
        end
        TBL_WAIT: begin
          if (abort_en) begin
            if (mem_resp_valid) begin
              done_q <= 1'b1;
              state  <= FAULT;
            end else begin
              state <= DRAIN;
            end
          end else if (mem_resp_valid) begin
            if (!mem_resp_data[0]) begin
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              ppage_q <= mem_resp_data[ADDR_WIDTH-1:PAGE_BITS];
              flags_q <= mem_resp_data[3:0];
              upd_q   <= 1'b1;
              done_q  <= 1'b1;
              state   <= UPDATE;
            end
          end
        end
        // FAULT is the one-cycle terminal state for every walk that ends
        // without a fill; fault_q tells a real fault from an abort.
        UPDATE, FAULT: state <= IDLE;
        DRAIN: begin
          if (mem_resp_valid) begin
            done_q <= 1'b1;
            state  <= FAULT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miss_ready    = (state == IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_valid_q ? addr_q : '0;

  // An abort arriving in the UPDATE/FAULT cycle itself cancels the fill or
  // fault indication; walk_done still pulses.
  assign update_en  = upd_q & ~abort_en;
  assign walk_fault = fault_q & ~abort_en;
  assign walk_done  = done_q;

  assign update_vpage_idx    = update_en ? vpage_q    : '0;
  assign update_asid         = update_en ? asid_q     : '0;
  assign update_ppage_idx    = update_en ? ppage_q    : '0;
  assign update_present      = update_en & flags_q[0];
  assign update_exe_writable = update_en & flags_q[1];
  assign update_supervisor   = update_en & flags_q[2];
  assign update_global       = update_en & flags_q[3];

  a_resp_in_wait: assert property (@(posedge clk) disable iff (reset)
    mem_resp_valid |-> (state == DIR_WAIT || state == TBL_WAIT || state == DRAIN));

  a_update_xor_fault: assert property (@(posedge clk) disable iff (reset)
    !(update_en && walk_fault));

endmodule

// File: tb/tb_tlb_miss_walker.sv
module tb_tlb_miss_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid;
  logic        miss_ready;
  logic [19:0] miss_vpage_idx;
  logic [7:0]  miss_asid;
  logic [31:0] page_dir_base;
  logic        abort_en;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        update_en;
  logic [19:0] update_vpage_idx;
  logic [7:0]  update_asid;
  logic [19:0] update_ppage_idx;
  logic        update_present;
  logic        update_exe_writable;
  logic        update_supervisor;
  logic        update_global;
  logic        walk_done;
  logic        walk_fault;

  tlb_miss_walker #(
    .ADDR_WIDTH(32), .PAGE_BITS(12), .DIR_INDEX_BITS(10), .ASID_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_vpage_idx(miss_vpage_idx), .miss_asid(miss_asid),
    .page_dir_base(page_dir_base), .abort_en(abort_en),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .update_en(update_en), .update_vpage_idx(update_vpage_idx),
    .update_asid(update_asid), .update_ppage_idx(update_ppage_idx),
    .update_present(update_present), .update_exe_writable(update_exe_writable),
    .update_supervisor(update_supervisor), .update_global(update_global),
    .walk_done(walk_done), .walk_fault(walk_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int req_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!reset && mem_req_valid && mem_req_ready) req_cnt <= req_cnt + 1;

  typedef struct {
    logic        upd;
    logic        fault;
    logic [19:0] vpage;
    logic [7:0]  asid;
    logic [19:0] ppage;
    logic [3:0]  flags;
    int          start;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic upd, input logic fault, input logic [19:0] vpage,
                      input logic [7:0] asid, input logic [19:0] ppage,
                      input logic [3:0] flags, input int start, input int lat);
    exp_t e;
    e.upd = upd; e.fault = fault; e.vpage = vpage; e.asid = asid;
    e.ppage = ppage; e.flags = flags; e.start = start; e.lat = lat;
    sbq.push_back(e);
  endtask

  task automatic issue_miss(input logic [19:0] vpage, input logic [7:0] asid,
                            input logic [31:0] base, output int start);
    chk("miss_ready in idle", miss_ready, 1);
    miss_valid     = 1'b1;
    miss_vpage_idx = vpage;
    miss_asid      = asid;
    page_dir_base  = base;
    start = cyc;
    tick();
    miss_valid = 1'b0;
    chk("miss_ready while walking", miss_ready, 0);
  endtask

  task automatic req_handshake(input logic [31:0] exp_addr, input int ready_wait);
    int w = 0;
    while (!mem_req_valid && w < 20) begin
      tick();
      w++;
    end
    chk("mem_req_valid", mem_req_valid, 1);
    for (int i = 0; i < ready_wait; i++) begin
      chk("req stable while stalled", {mem_req_valid, mem_req_addr}, {1'b1, exp_addr});
      tick();
    end
    chk("mem_req_addr", mem_req_addr, exp_addr);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sbq.size() > 0 && w < 50) begin
      tick();
      w++;
    end
    if (sbq.size() > 0) begin
      chk("walk_done timeout", sbq.size(), 0);
      sbq.delete();
    end
    tick();
  endtask

  // Monitor: pops one expectation per walk_done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (walk_done) begin
          if (sbq.size() == 0) begin
            chk("unexpected walk_done", walk_done, 0);
          end else begin
            e = sbq.pop_front();
            chk("done kind {update_en,walk_fault}", {update_en, walk_fault}, {e.upd, e.fault});
            if (e.upd)
              chk("update fields",
                  {update_vpage_idx, update_asid, update_ppage_idx,
                   update_global, update_supervisor, update_exe_writable, update_present},
                  {e.vpage, e.asid, e.ppage, e.flags});
            if (e.lat >= 0) chk("walk latency", cyc - e.start, e.lat);
          end
        end else if (update_en) begin
          chk("update_en without walk_done", update_en, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    int st;
    int r0;
    reset = 1'b1; miss_valid = 1'b0; miss_vpage_idx = '0; miss_asid = '0;
    page_dir_base = '0; abort_en = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset state", {miss_ready, mem_req_valid, update_en, walk_done, walk_fault},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    // Full walk, zero-wait memory
    issue_miss(20'h00403, 8'h11, 32'h0001_0000, st);
    push(1, 0, 20'h00403, 8'h11, 20'h0ABCD, 4'hF, st, 5);
    r0 = req_cnt;
    req_handshake(32'h0001_0004, 0);
    respond(32'h0002_0001);
    req_handshake(32'h0002_000C, 0);
    respond(32'h0ABC_D00F);
    wait_drain();
    chk("fill: two requests", req_cnt - r0, 2);

    // Directory entry not present
    issue_miss(20'h00403, 8'h22, 32'h0001_0000, st);
    push(0, 1, 20'h00403, 8'h22, 20'h0, 4'h0, st, 3);
    r0 = req_cnt;
    req_handshake(32'h0001_0004, 0);
    respond(32'h0002_0000);
    wait_drain();
    chk("dir fault: one request", req_cnt - r0, 1);
    chk("dir fault: no further request", mem_req_valid, 0);

    // Leaf entry not present
    issue_miss(20'h00403, 8'h33, 32'h0001_0000, st);
    push(0, 1, 20'h00403, 8'h33, 20'h0, 4'h0, st, 5);
    r0 = req_cnt;
    req_handshake(32'h0001_0004, 0);
    respond(32'h0002_0001);
    req_handshake(32'h0002_000C, 0);
    respond(32'h0ABC_D002);
    wait_drain();
    chk("leaf fault: two requests", req_cnt - r0, 2);

    // Seven-cycle stall on the directory request; base add wraps
    issue_miss(20'hFFC01, 8'h44, 32'hFFFF_F800, st);
    push(1, 0, 20'hFFC01, 8'h44, 20'h00056, 4'h3, st, 12);
    req_handshake(32'h0000_07FC, 7);
    respond(32'h1234_5001);
    req_handshake(32'h1234_5004, 0);
    respond(32'h0005_6003);
    wait_drain();

    // Abort in DIR_WAIT, response three cycles later is drained
    issue_miss(20'h00403, 8'h55, 32'h0001_0000, st);
    push(0, 0, 20'h00403, 8'h55, 20'h0, 4'h0, st, 6);
    r0 = req_cnt;
    req_handshake(32'h0001_0004, 0);
    abort_en = 1'b1;
    tick();
    abort_en = 1'b0;
    tick();
    tick();
    respond(32'h0002_0001);
    wait_drain();
    chk("drain: one request", req_cnt - r0, 1);

    // Next miss walks normally
    issue_miss(20'h00C05, 8'h56, 32'h0004_0000, st);
    push(1, 0, 20'h00C05, 8'h56, 20'h00999, 4'h5, st, 5);
    req_handshake(32'h0004_000C, 0);
    respond(32'h0007_7001);
    req_handshake(32'h0007_7014, 0);
    respond(32'h0099_9005);
    wait_drain();

    // Abort in DIR_REQ before any handshake
    issue_miss(20'h00403, 8'h60, 32'h0001_0000, st);
    push(0, 0, 20'h00403, 8'h60, 20'h0, 4'h0, st, 2);
    r0 = req_cnt;
    abort_en = 1'b1;
    tick();
    abort_en = 1'b0;
    wait_drain();
    chk("req abort: no handshake", req_cnt - r0, 0);
    chk("req abort: request dropped", mem_req_valid, 0);

    // Abort and response in the same DIR_WAIT cycle
    issue_miss(20'h00403, 8'h61, 32'h0001_0000, st);
    push(0, 0, 20'h00403, 8'h61, 20'h0, 4'h0, st, 3);
    req_handshake(32'h0001_0004, 0);
    abort_en = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0002_0001;
    tick();
    abort_en = 1'b0;
    mem_resp_valid = 1'b0;
    wait_drain();
    chk("abort+resp: back in idle", miss_ready, 1);

    // Abort in the UPDATE cycle suppresses the fill
    issue_miss(20'h00403, 8'h62, 32'h0001_0000, st);
    push(0, 0, 20'h00403, 8'h62, 20'h0, 4'h0, st, 5);
    req_handshake(32'h0001_0004, 0);
    respond(32'h0002_0001);
    req_handshake(32'h0002_000C, 0);
    respond(32'h0ABC_D00F);
    abort_en = 1'b1;
    tick();
    abort_en = 1'b0;
    wait_drain();

    // Reset while in TBL_WAIT
    issue_miss(20'h00403, 8'h70, 32'h0001_0000, st);
    req_handshake(32'h0001_0004, 0);
    respond(32'h0002_0001);
    req_handshake(32'h0002_000C, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("outputs after reset in TBL_WAIT",
        {miss_ready, mem_req_valid, mem_req_addr, update_en, walk_done, walk_fault, update_ppage_idx},
        {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 20'h0});

    // Walk after reset
    issue_miss(20'h00403, 8'h77, 32'h0001_0000, st);
    push(1, 0, 20'h00403, 8'h77, 20'h0ABCD, 4'hF, st, 5);
    req_handshake(32'h0001_0004, 0);
    respond(32'h0002_0001);
    req_handshake(32'h0002_000C, 0);
    respond(32'h0ABC_D00F);
    wait_drain();

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
